// File: rtl/fastreadout_pkg.sv
// Shared types and constants for the fast readout path.
//   router_state_t : packet router FSM states
//   HDR_MARK       : bit 7 of every header byte
//   PKT_BYTES      : bytes per period packet (header, MSB, LSB)
package fastreadout_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StMsb  = 2'd2,
    StLsb  = 2'd3
  } router_state_t;

  localparam logic        HDR_MARK  = 1'b1;
  localparam int unsigned PKT_BYTES = 3;

endpackage

// File: rtl/period_packet_router_if.sv
// Byte stream carrying period packets from the router to the output pins.
//   data_out   : packet byte
//   data_valid : data_out holds a valid byte
//   pkt_start  : high with data_valid on header bytes only
//   out_ready  : consumer accepts the current byte
// master = router side, slave = consumer side.
interface period_packet_router_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_start;
  logic       out_ready;

  modport master (
    output data_out,
    output data_valid,
    output pkt_start,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  pkt_start,
    output out_ready
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index strictly after the
// last-granted one, wrapping around. The pointer starts at N-1 so index 0
// wins first after reset.
//   clk, rst_n  : clock, async active-low reset
//   req         : request vector
//   advance     : current grant is being taken; move the pointer to it
//   grant_idx   : granted index (valid when grant_valid)
//   grant_valid : at least one request is pending
module round_robin_arbiter #(
  parameter  int unsigned N    = 8,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_valid
);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(last_q) + k) % N;
      cand_idx = IdxW'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IdxW'(N - 1);
    end else if (advance && grant_valid) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/period_packet_router.sv
// Collects per-pixel period measurements into single-entry holding buffers
// and serialises them as 3-byte packets {header, MSB, LSB} on a byte stream.
//   clk, rst_n   : clock, async active-low reset
//   period       : PIXELS packed periods, pixel i at [i*COUNTER_BITS +: COUNTER_BITS]
//   period_valid : per-pixel strobe marking a new period value
//   drop_count   : saturating count of measurements overwritten before sending
//   pkt          : output byte stream (data_out/data_valid/pkt_start/out_ready)
// Header = {1, ovf, 0, idx[4:0]}, MSB = {0, value[14:8]}, LSB = value[7:0].
module period_packet_router
  import fastreadout_pkg::*;
#(
  parameter int unsigned PIXELS       = 8,
  parameter int unsigned COUNTER_BITS = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PIXELS*COUNTER_BITS-1:0] period,
  input  logic [PIXELS-1:0]              period_valid,
  output logic [7:0]                     drop_count,
  period_packet_router_if.master         pkt
);

  localparam int unsigned IdxW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  router_state_t state_q, state_d;

  logic [PIXELS-1:0]       pend_q, pend_d;
  logic [PIXELS-1:0]       ovf_q, ovf_d;
  logic [COUNTER_BITS-1:0] pbuf_q [PIXELS];
  logic [COUNTER_BITS-1:0] pbuf_d [PIXELS];
  logic [14:0]             shadow_q, shadow_d;
  logic [7:0]              data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    start_q, start_d;
  logic [7:0]              drop_q, drop_d;

  logic [IdxW-1:0]   grant_idx;
  logic              grant_valid;
  logic              grant_en;
  logic              transfer;
  logic [PIXELS-1:0] drop_ev;
  logic [5:0]        drops;
  logic [8:0]        drop_sum;
  logic [7:0]        header;

  assign transfer = valid_q && pkt.out_ready;
  // A new packet may start when idle, or as the last byte of the current one leaves.
  assign grant_en = grant_valid && ((state_q == StIdle) || ((state_q == StLsb) && transfer));
  assign header   = {HDR_MARK, ovf_q[grant_idx], 1'b0, 5'(grant_idx)};

  round_robin_arbiter #(
    .N (PIXELS)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (pend_q),
    .advance     (grant_en),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Capture and drop accounting. A strobe on the pixel being granted refills
  // its buffer without counting as a loss; the shadow still takes the old value.
  always_comb begin
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    pbuf_d  = pbuf_q;
    drop_ev = '0;
    for (int i = 0; i < PIXELS; i++) begin
      if (grant_en && (grant_idx == IdxW'(i))) begin
        pend_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end
      if (period_valid[i]) begin
        pbuf_d[i] = period[i*COUNTER_BITS +: COUNTER_BITS];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(grant_en && (grant_idx == IdxW'(i)))) begin
          ovf_d[i]   = 1'b1;
          drop_ev[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drops = '0;
    for (int i = 0; i < PIXELS; i++) begin
      drops = drops + 6'(drop_ev[i]);
    end
    drop_sum = {1'b0, drop_q} + {3'b000, drops};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Output FSM. data_out only moves on a transfer or a fresh grant, so it is
  // stable while the consumer stalls.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    start_d  = start_q;
    shadow_d = shadow_q;
    if (grant_en) begin
      shadow_d = 15'(pbuf_q[grant_idx]);
      data_d   = header;
      valid_d  = 1'b1;
      start_d  = 1'b1;
      state_d  = StHdr;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHdr: begin
          if (transfer) begin
            state_d = StMsb;
            data_d  = {1'b0, shadow_q[14:8]};
            start_d = 1'b0;
          end
        end
        StMsb: begin
          if (transfer) begin
            state_d = StLsb;
            data_d  = shadow_q[7:0];
          end
        end
        StLsb: begin
          if (transfer) begin
            state_d = StIdle;
            valid_d = 1'b0;
            start_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      ovf_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      drop_q   <= '0;
      for (int i = 0; i < PIXELS; i++) begin
        pbuf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      drop_q   <= drop_d;
      pbuf_q   <= pbuf_d;
    end
  end

  assign pkt.data_out   = data_q;
  assign pkt.data_valid = valid_q;
  assign pkt.pkt_start  = start_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_period_packet_router.sv
module tb_period_packet_router;
  import fastreadout_pkg::*;

  localparam int P  = 8;
  localparam int CB = 15;
  localparam int PW = P * CB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] period = '0;
  logic [P-1:0]  period_valid = '0;
  logic [7:0]    drop_count;

  period_packet_router_if bus ();

  period_packet_router #(
    .PIXELS       (P),
    .COUNTER_BITS (CB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .period       (period),
    .period_valid (period_valid),
    .drop_count   (drop_count),
    .pkt          (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: pixels hold a value + pending/overflow flag,
  // the stream carries whole packets, and a new packet is chosen whenever the
  // stream is free (nothing outstanding, or the last byte is being accepted).
  logic [14:0] m_val [P];
  bit          m_pend [P];
  bit          m_ovf [P];
  int          m_last, m_left, m_drop;
  logic [7:0]  m_pkt [PKT_BYTES];

  function automatic void model_reset();
    for (int i = 0; i < P; i++) begin
      m_val[i] = '0; m_pend[i] = 0; m_ovf[i] = 0;
    end
    m_last = P - 1; m_left = 0; m_drop = 0;
  endfunction

  function automatic void model_cycle(input logic [P-1:0] pv, input logic [PW-1:0] per,
                                      input logic rdy);
    bit xfer, free;
    int g, c;
    xfer = (m_left > 0) && rdy;
    free = (m_left == 0) || (m_left == 1 && xfer);
    g = -1;
    if (free) begin
      for (int k = 1; k <= P; k++) begin
        c = (m_last + k) % P;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (xfer) m_left--;
    if (g >= 0) begin
      m_pkt[0] = {1'b1, m_ovf[g] ? 1'b1 : 1'b0, 1'b0, 5'(g)};
      m_pkt[1] = {1'b0, m_val[g][14:8]};
      m_pkt[2] = m_val[g][7:0];
      m_left = PKT_BYTES;
      m_pend[g] = 0; m_ovf[g] = 0; m_last = g;
    end
    for (int i = 0; i < P; i++) begin
      if (pv[i]) begin
        if (m_pend[i]) begin
          m_ovf[i] = 1;
          if (m_drop < 255) m_drop++;
        end
        m_pend[i] = 1;
        m_val[i] = per[i*CB +: CB];
      end
    end
  endfunction

  function automatic logic [PW-1:0] rep(input logic [14:0] v);
    logic [PW-1:0] r;
    for (int i = 0; i < P; i++) r[i*CB +: CB] = v;
    return r;
  endfunction

  task automatic check_model();
    check("valid", 32'(bus.data_valid), (m_left > 0) ? 1 : 0);
    check("pkt_start", 32'(bus.pkt_start), (m_left == PKT_BYTES) ? 1 : 0);
    if (m_left > 0) check("data_out", 32'(bus.data_out), 32'(m_pkt[PKT_BYTES - m_left]));
    check("drop_count", 32'(drop_count), m_drop);
  endtask

  // One clock: apply inputs, advance model, sample #1 after the edge.
  task automatic cyc(input logic [P-1:0] pv, input logic [PW-1:0] per, input logic rdy);
    period_valid  = pv;
    period        = per;
    bus.out_ready = rdy;
    model_cycle(pv, per, rdy);
    @(posedge clk);
    #1;
    check_model();
    period_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; period_valid = '0; bus.out_ready = 1'b0;
    #1;
    check("rst data_out", 32'(bus.data_out), 0);
    check("rst valid", 32'(bus.data_valid), 0);
    check("rst pkt_start", 32'(bus.pkt_start), 0);
    check("rst drop_count", 32'(drop_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  logic [7:0] hdr_q[$];
  always @(posedge clk)
    if (rst_n && bus.data_valid && bus.out_ready && bus.pkt_start) hdr_q.push_back(bus.data_out);

  typedef struct packed {
    logic [7:0]  pv;
    logic [14:0] val;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        es;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int vcount;
    logic [7:0] exp_hdr [13];
    logic [PW-1:0] per;
    logic [P-1:0]  pv;

    // Single packet, overwrite/drop, and ovf clearing on the next packet.
    vecs[0]  = '{8'h08, 15'h1234, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[1]  = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h83, 1'b1, 8'd0};
    vecs[2]  = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h12, 1'b0, 8'd0};
    vecs[3]  = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h34, 1'b0, 8'd0};
    vecs[4]  = '{8'h00, 15'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[5]  = '{8'h01, 15'h0055, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[6]  = '{8'h04, 15'h0100, 1'b0, 1'b1, 8'h80, 1'b1, 8'd0};
    vecs[7]  = '{8'h04, 15'h0200, 1'b0, 1'b1, 8'h80, 1'b1, 8'd1};
    vecs[8]  = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 8'd1};
    vecs[9]  = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h55, 1'b0, 8'd1};
    vecs[10] = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'hC2, 1'b1, 8'd1};
    vecs[11] = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h02, 1'b0, 8'd1};
    vecs[12] = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 8'd1};
    vecs[13] = '{8'h00, 15'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1};
    vecs[14] = '{8'h04, 15'h0077, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1};
    vecs[15] = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h82, 1'b1, 8'd1};
    vecs[16] = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 8'd1};
    vecs[17] = '{8'h00, 15'h0000, 1'b1, 1'b1, 8'h77, 1'b0, 8'd1};
    vecs[18] = '{8'h00, 15'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1};

    bus.out_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      period_valid  = vecs[i].pv;
      period        = rep(vecs[i].val);
      bus.out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d valid", i), 32'(bus.data_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d pkt_start", i), 32'(bus.pkt_start), 32'(vecs[i].es));
      if (vecs[i].ev) check($sformatf("vec%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].ed));
      check($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(vecs[i].edrop));
    end
    period_valid = '0;

    // Round-robin: all pixels at once, then pixels 1,3, then 0,2,5.
    do_reset();
    hdr_q.delete();
    for (int i = 0; i < P; i++) per[i*CB +: CB] = 15'(i);
    cyc(8'hFF, per, 1'b1);
    vcount = 0;
    for (int i = 0; i < 27; i++) begin
      cyc(8'h00, per, 1'b1);
      if (bus.data_valid) vcount++;
    end
    check("rr valid cycles", 32'(vcount), 24);
    cyc(8'h0A, per, 1'b1);
    for (int i = 0; i < 8; i++) cyc(8'h00, per, 1'b1);
    cyc(8'h25, per, 1'b1);
    for (int i = 0; i < 12; i++) cyc(8'h00, per, 1'b1);
    for (int i = 0; i < 8; i++) exp_hdr[i] = 8'h80 + 8'(i);
    exp_hdr[8] = 8'h81; exp_hdr[9] = 8'h83;
    exp_hdr[10] = 8'h85; exp_hdr[11] = 8'h80; exp_hdr[12] = 8'h82;
    check("rr header count", 32'(hdr_q.size()), 13);
    for (int i = 0; i < 13; i++)
      if (i < hdr_q.size()) check($sformatf("rr header %0d", i), 32'(hdr_q[i]), 32'(exp_hdr[i]));

    // Backpressure: stall 10 cycles while the MSB byte is presented.
    cyc(8'h10, rep(15'h5A3C), 1'b1);
    cyc(8'h00, '0, 1'b1);
    check("bp header", 32'(bus.data_out), 32'h84);
    cyc(8'h00, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, '0, 1'b0);
      check("bp msb stable", 32'(bus.data_out), 32'h5A);
    end
    cyc(8'h00, '0, 1'b1);
    check("bp lsb", 32'(bus.data_out), 32'h3C);
    cyc(8'h00, '0, 1'b1);

    // Grant-cycle collision on pixel 5.
    cyc(8'h20, rep(15'h0111), 1'b1);
    cyc(8'h20, rep(15'h0222), 1'b1);
    check("coll header", 32'(bus.data_out), 32'h85);
    for (int i = 0; i < 7; i++) cyc(8'h00, '0, 1'b1);
    check("coll no drop", 32'(drop_count), 32'(m_drop));

    // Drop counter saturation with the stream stalled.
    do_reset();
    cyc(8'h01, rep(15'h0001), 1'b0);
    cyc(8'h00, '0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(8'hFF, rep(15'(i)), 1'b0);
    check("drop saturated", 32'(drop_count), 255);
    for (int i = 0; i < 30; i++) cyc(8'h00, '0, 1'b1);

    // Reset in the middle of a packet.
    do_reset();
    cyc(8'h02, rep(15'h0ABC), 1'b1);
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst valid", 32'(bus.data_valid), 0);
    check("midrst data_out", 32'(bus.data_out), 0);
    check("midrst pkt_start", 32'(bus.pkt_start), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, '0, 1'b1);
      check("post-rst idle", 32'(bus.data_valid), 0);
    end

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < P; i++) begin
        pv[i] = ($urandom_range(11) == 0);
        per[i*CB +: CB] = 15'($urandom);
      end
      cyc(pv, per, $urandom_range(3) != 0);
    end
    for (int i = 0; i < 40; i++) cyc(8'h00, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
